frame_writer: RTL

//   Fills the frame RAM that the VGA display path reads. Takes a byte stream
//   (UART receiver or SD loader), packs byte pairs into 12-bit RGB pixels and

---
 rtl/frame_writer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/frame_writer.sv
// Packs a byte stream into 12-bit RGB pixels and writes one W x H frame to RAM
// in raster order; an idle timeout discards a half-received pixel.
module frame_writer #(
   parameter int unsigned W       = 200,
   parameter int unsigned H       = 150,
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [11:0]       ram_wdata,
   output logic              busy,
   output logic              done,
   output logic [7:0]        drop_cnt
);

   localparam int unsigned NPIX = W * H;
   localparam int unsigned TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

   state_t            r_state, w_state;
   logic [ADDR_W-1:0] r_pix, w_pix;
   logic [TW-1:0]     r_timer, w_timer;
   logic [3:0]        r_red, w_red;
   logic              r_we, w_we;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [11:0]       r_wdata, w_wdata;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic [7:0]        r_drop, w_drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_pix   <= '0;
         r_timer <= '0;
         r_red   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= '0;
      end else begin
         r_state <= w_state;
         r_pix   <= w_pix;
         r_timer <= w_timer;
         r_red   <= w_red;
         r_we    <= w_we;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_drop  <= w_drop;
      end
   end

   always_comb begin
      w_state = r_state;
      w_pix   = r_pix;
      w_timer = r_timer;
      w_red   = r_red;
      w_we    = 1'b0;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_done  = r_done;
      w_drop  = r_drop;
      // start overrides everything, including a byte arriving in the same cycle
      if (start) begin
         w_state = HI;
         w_pix   = '0;
         w_timer = '0;
         w_done  = 1'b0;
         w_drop  = '0;
      end else begin
         unique case (r_state)
            HI: begin
               if (byte_valid) begin
                  w_red   = byte_data[3:0];
                  w_timer = '0;
                  w_state = LO;
               end
            end
            LO: begin
               if (byte_valid) begin
                  w_we    = 1'b1;
                  w_addr  = r_pix;
                  w_wdata = {r_red, byte_data};
                  if (r_pix == ADDR_W'(NPIX - 1)) begin
                     w_state = DONE;
                     w_done  = 1'b1;
                  end else begin
                     w_pix   = r_pix + 1'b1;
                     w_state = HI;
                  end
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  w_state = HI;
                  w_timer = '0;
                  if (r_drop != 8'hFF) w_drop = r_drop + 8'd1;
               end else begin
                  w_timer = r_timer + 1'b1;
               end
            end
            default: ;
         endcase
      end
      w_busy = (w_state == HI) || (w_state == LO);
   end

   assign ram_we    = r_we;
   assign ram_addr  = r_addr;
   assign ram_wdata = r_wdata;
   assign busy      = r_busy;
   assign done      = r_done;
   assign drop_cnt  = r_drop;

endmodule
